// File: rtl/dac_fill.sv
// DAC sample-buffer filler: primes the 2 KB ping-pong buffer from the SD DMA stream, then refills whichever half the DAC has vacated.
// Optional build macro DAC_FILL_UNDERRUN_MUTE_EN mutes play from an underrun until the restarted refill completes.
module dac_fill #(
  parameter int PRIME_HALVES = 2
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        dac_status,
  output logic [10:0] pgm_address,
  output logic [7:0]  pgm_data,
  output logic        pgm_we_n,
  output logic        fill_req,
  output logic        play,
  output logic        underrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_WAIT,
    ST_REFILL
  } state_t;

  localparam logic [10:0] PRIME_LAST  = 11'(PRIME_HALVES * 1024 - 1);
  localparam logic [10:0] REFILL_LAST = 11'd1023;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_d;
  logic [10:0] r_wptr;
  logic [10:0] r_cnt;
  logic        r_play;
  logic        r_underrun;
  logic [10:0] r_pgm_address;
  logic [7:0]  r_pgm_data;
  logic        r_pgm_we_n;

  state_t      w_state_next;
  logic [10:0] w_wptr_next;
  logic [10:0] w_cnt_next;
  logic        w_play_next;
  logic        w_underrun_next;
  logic [10:0] w_addr_next;
  logic [7:0]  w_data_next;
  logic        w_we_n_next;
  logic        w_fill_req;
  logic        w_xfer;
  logic        w_toggle;
  logic [10:0] w_vacated_base;

  assign w_fill_req     = (r_state == ST_PRIME) || (r_state == ST_REFILL);
  assign w_xfer         = src_valid && w_fill_req;
  assign w_toggle       = r_sync2 ^ r_sync_d;
  // The DAC reads the half named by the synchronized status, so the other half is free.
  assign w_vacated_base = {~r_sync2, 10'h000};

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= dac_status;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_wptr        <= 11'd0;
      r_cnt         <= 11'd0;
      r_play        <= 1'b0;
      r_underrun    <= 1'b0;
      r_pgm_address <= 11'd0;
      r_pgm_data    <= 8'd0;
      r_pgm_we_n    <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_wptr        <= w_wptr_next;
      r_cnt         <= w_cnt_next;
      r_play        <= w_play_next;
      r_underrun    <= w_underrun_next;
      r_pgm_address <= w_addr_next;
      r_pgm_data    <= w_data_next;
      r_pgm_we_n    <= w_we_n_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wptr_next     = r_wptr;
    w_cnt_next      = r_cnt;
    w_play_next     = r_play;
    w_underrun_next = r_underrun;
    w_addr_next     = r_pgm_address;
    w_data_next     = r_pgm_data;
    w_we_n_next     = 1'b1;

    if (w_xfer) begin
      w_we_n_next = 1'b0;
      w_addr_next = r_wptr;
      w_data_next = src_data;
      w_wptr_next = r_wptr + 11'd1;
      w_cnt_next  = r_cnt + 11'd1;
    end

    if (stop) begin
      w_state_next = ST_IDLE;
      w_play_next  = 1'b0;
      w_we_n_next  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_next    = ST_PRIME;
            w_wptr_next     = 11'd0;
            w_cnt_next      = 11'd0;
            w_underrun_next = 1'b0;
            w_play_next     = 1'b0;
          end
        end
        ST_PRIME: begin
          if (w_xfer && (r_cnt == PRIME_LAST)) begin
            w_state_next = ST_WAIT;
            w_play_next  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_toggle) begin
            w_state_next = ST_REFILL;
            w_wptr_next  = w_vacated_base;
            w_cnt_next   = 11'd0;
          end
        end
        ST_REFILL: begin
          if (w_xfer && (r_cnt == REFILL_LAST)) begin
            // A coincident toggle is a clean completion followed by a fresh refill.
            if (w_toggle) begin
              w_wptr_next = w_vacated_base;
              w_cnt_next  = 11'd0;
            end else begin
              w_state_next = ST_WAIT;
            end
`ifdef DAC_FILL_UNDERRUN_MUTE_EN
            w_play_next = 1'b1;
`endif
          end else if (w_toggle) begin
            w_underrun_next = 1'b1;
            w_wptr_next     = w_vacated_base;
            w_cnt_next      = 11'd0;
`ifdef DAC_FILL_UNDERRUN_MUTE_EN
            w_play_next     = 1'b0;
`endif
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign fill_req    = w_fill_req;
  assign src_ready   = w_fill_req;
  assign play        = r_play;
  assign underrun    = r_underrun;
  assign pgm_address = r_pgm_address;
  assign pgm_data    = r_pgm_data;
  assign pgm_we_n    = r_pgm_we_n;

endmodule

// File: tb/tb_dac_fill.sv
// Directed bench for dac_fill: prime, refill, backpressure, underrun, stop/start and async reset.
module tb_dac_fill;

  logic        clkin = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic        dac_status;
  logic [10:0] pgm_address;
  logic [7:0]  pgm_data;
  logic        pgm_we_n;
  logic        fill_req;
  logic        play;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_addr;
  logic [7:0]  exp_data;
  logic        acc;
  int          nwr;
  int          guard;

`ifdef DAC_FILL_UNDERRUN_MUTE_EN
  localparam logic PLAY_DURING_UNDERRUN = 1'b0;
`else
  localparam logic PLAY_DURING_UNDERRUN = 1'b1;
`endif

  dac_fill #(.PRIME_HALVES(2)) dut (
    .clkin       (clkin),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .dac_status  (dac_status),
    .pgm_address (pgm_address),
    .pgm_data    (pgm_data),
    .pgm_we_n    (pgm_we_n),
    .fill_req    (fill_req),
    .play        (play),
    .underrun    (underrun)
  );

  always #5 clkin = ~clkin;

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; stop = 1'b0;
    src_data = 8'd0; src_valid = 1'b0; dac_status = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (pgm_we_n !== 1'b1 || pgm_address !== 11'd0 || pgm_data !== 8'd0 || play !== 1'b0 ||
        fill_req !== 1'b0 || src_ready !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_async we_n=%b addr=%h data=%h play=%b fill=%b rdy=%b unr=%b required 1 000 00 0 0 0 0",
               pgm_we_n, pgm_address, pgm_data, play, fill_req, src_ready, underrun);
    end
    repeat (3) @(posedge clkin);
    #1 reset_n = 1'b1;
    @(posedge clkin); #1;
    checks++;
    if (fill_req !== 1'b0 || pgm_we_n !== 1'b1 || play !== 1'b0) begin
      errors++;
      $display("FAIL reset_release fill=%b we_n=%b play=%b required 0 1 0", fill_req, pgm_we_n, play);
    end
  endtask

  task automatic test_prime();
    start = 1'b1;
    @(posedge clkin); #1;
    start = 1'b0;
    checks++;
    if (fill_req !== 1'b1 || play !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL prime_start fill=%b play=%b unr=%b required 1 0 0", fill_req, play, underrun);
    end
    exp_addr = 11'd0; nwr = 0; guard = 0;
    while (nwr < 2048 && guard < 4000) begin
      src_valid = 1'b1;
      exp_data  = exp_addr[7:0] ^ 8'hA5;
      src_data  = exp_data;
      checks++;
      if (src_ready !== 1'b1) begin
        errors++;
        $display("FAIL prime_ready byte=%0d got=%b required 1", nwr, src_ready);
      end
      acc = src_valid;
      @(posedge clkin); #1;
      guard++;
      checks++;
      if (acc) begin
        if (pgm_we_n !== 1'b0 || pgm_address !== exp_addr || pgm_data !== exp_data) begin
          errors++;
          $display("FAIL prime_write we_n=%b addr=%h data=%h required 0 %h %h",
                   pgm_we_n, pgm_address, pgm_data, exp_addr, exp_data);
        end
        exp_addr = exp_addr + 11'd1;
        nwr++;
      end
    end
    src_valid = 1'b0;
    if (guard >= 4000) begin
      errors++;
      $display("FAIL prime_timeout writes=%0d required 2048", nwr);
    end
    checks++;
    if (play !== 1'b1 || fill_req !== 1'b0) begin
      errors++;
      $display("FAIL prime_done play=%b fill=%b required 1 0", play, fill_req);
    end
  endtask

  // Toggles dac_status and checks fill_req rises exactly on the third edge.
  task automatic test_refill_toggle_latency(input logic new_status);
    dac_status = new_status;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clkin); #1;
      checks++;
      if (fill_req !== (i == 3)) begin
        errors++;
        $display("FAIL toggle_latency edge=%0d fill=%b required %b", i, fill_req, (i == 3));
      end
    end
  endtask

  task automatic test_refill();
    test_refill_toggle_latency(1'b1);
    exp_addr = 11'h000; nwr = 0; guard = 0;
    while (nwr < 1024 && guard < 3000) begin
      src_valid = 1'b1;
      exp_data  = exp_addr[7:0] ^ 8'h3C;
      src_data  = exp_data;
      acc = src_valid;
      @(posedge clkin); #1;
      guard++;
      checks++;
      if (pgm_we_n !== 1'b0 || pgm_address !== exp_addr || pgm_data !== exp_data) begin
        errors++;
        $display("FAIL refill_write we_n=%b addr=%h data=%h required 0 %h %h",
                 pgm_we_n, pgm_address, pgm_data, exp_addr, exp_data);
      end
      exp_addr = exp_addr + 11'd1;
      nwr++;
    end
    src_valid = 1'b0;
    if (guard >= 3000) begin
      errors++;
      $display("FAIL refill_timeout writes=%0d required 1024", nwr);
    end
    @(posedge clkin); #1;
    checks++;
    if (fill_req !== 1'b0 || play !== 1'b1 || pgm_we_n !== 1'b1) begin
      errors++;
      $display("FAIL refill_done fill=%b play=%b we_n=%b required 0 1 1", fill_req, play, pgm_we_n);
    end
  endtask

  task automatic test_backpressure();
    test_refill_toggle_latency(1'b0);
    exp_addr = 11'h400; nwr = 0; guard = 0;
    src_valid = 1'b0;
    while (nwr < 1024 && guard < 4000) begin
      src_valid = ~src_valid;
      exp_data  = exp_addr[7:0] ^ 8'h69;
      src_data  = exp_data;
      acc = src_valid;
      @(posedge clkin); #1;
      guard++;
      checks++;
      if (acc) begin
        if (pgm_we_n !== 1'b0 || pgm_address !== exp_addr || pgm_data !== exp_data) begin
          errors++;
          $display("FAIL bp_write we_n=%b addr=%h data=%h required 0 %h %h",
                   pgm_we_n, pgm_address, pgm_data, exp_addr, exp_data);
        end
        exp_addr = exp_addr + 11'd1;
        nwr++;
      end else if (pgm_we_n !== 1'b1) begin
        errors++;
        $display("FAIL bp_idle_cycle we_n=%b required 1", pgm_we_n);
      end
    end
    src_valid = 1'b0;
    if (guard >= 4000) begin
      errors++;
      $display("FAIL bp_timeout writes=%0d required 1024", nwr);
    end
    checks++;
    if (fill_req !== 1'b0 || exp_addr !== 11'h000) begin
      errors++;
      $display("FAIL bp_done fill=%b next_addr=%h required 0 000", fill_req, exp_addr);
    end
  endtask

  task automatic test_underrun();
    test_refill_toggle_latency(1'b1);
    exp_addr = 11'h000;
    for (int i = 0; i < 500; i++) begin
      src_valid = 1'b1;
      src_data  = exp_addr[7:0];
      @(posedge clkin); #1;
      exp_addr = exp_addr + 11'd1;
    end
    src_valid  = 1'b0;
    dac_status = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    checks++;
    if (underrun !== 1'b1 || fill_req !== 1'b1 || play !== PLAY_DURING_UNDERRUN) begin
      errors++;
      $display("FAIL underrun_flag unr=%b fill=%b play=%b required 1 1 %b",
               underrun, fill_req, play, PLAY_DURING_UNDERRUN);
    end
    exp_addr = 11'h400; nwr = 0; guard = 0;
    while (nwr < 1024 && guard < 3000) begin
      src_valid = 1'b1;
      exp_data  = exp_addr[7:0] ^ 8'h0F;
      src_data  = exp_data;
      @(posedge clkin); #1;
      guard++;
      checks++;
      if (pgm_we_n !== 1'b0 || pgm_address !== exp_addr || pgm_data !== exp_data) begin
        errors++;
        $display("FAIL underrun_restart_write we_n=%b addr=%h data=%h required 0 %h %h",
                 pgm_we_n, pgm_address, pgm_data, exp_addr, exp_data);
      end
      exp_addr = exp_addr + 11'd1;
      nwr++;
      if (nwr == 1023) begin
        checks++;
        if (play !== PLAY_DURING_UNDERRUN) begin
          errors++;
          $display("FAIL underrun_play_mid got=%b required %b", play, PLAY_DURING_UNDERRUN);
        end
      end
    end
    src_valid = 1'b0;
    if (guard >= 3000) begin
      errors++;
      $display("FAIL underrun_timeout writes=%0d required 1024", nwr);
    end
    checks++;
    if (play !== 1'b1 || underrun !== 1'b1 || fill_req !== 1'b0) begin
      errors++;
      $display("FAIL underrun_done play=%b unr=%b fill=%b required 1 1 0", play, underrun, fill_req);
    end
  endtask

  task automatic test_stop_start();
    stop = 1'b1;
    @(posedge clkin); #1;
    stop = 1'b0;
    checks++;
    if (play !== 1'b0 || fill_req !== 1'b0 || underrun !== 1'b1 || pgm_we_n !== 1'b1) begin
      errors++;
      $display("FAIL stop_idle play=%b fill=%b unr=%b we_n=%b required 0 0 1 1",
               play, fill_req, underrun, pgm_we_n);
    end
    start = 1'b1; stop = 1'b1; src_valid = 1'b1;
    @(posedge clkin); #1;
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fill_req !== 1'b0 || pgm_we_n !== 1'b1 || underrun !== 1'b1) begin
        errors++;
        $display("FAIL stop_beats_start cyc=%0d fill=%b we_n=%b unr=%b required 0 1 1",
                 i, fill_req, pgm_we_n, underrun);
      end
      @(posedge clkin); #1;
    end
    src_valid = 1'b0;
  endtask

  task automatic test_reset_mid_prime();
    start = 1'b1;
    @(posedge clkin); #1;
    start = 1'b0;
    checks++;
    if (underrun !== 1'b0 || fill_req !== 1'b1 || play !== 1'b0) begin
      errors++;
      $display("FAIL restart_clears unr=%b fill=%b play=%b required 0 1 0", underrun, fill_req, play);
    end
    for (int i = 0; i < 300; i++) begin
      src_valid = 1'b1;
      src_data  = 8'hC3;
      @(posedge clkin); #1;
    end
    checks++;
    if (pgm_we_n !== 1'b0 || pgm_address !== 11'd299) begin
      errors++;
      $display("FAIL prime_300 we_n=%b addr=%h required 0 12b", pgm_we_n, pgm_address);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pgm_we_n !== 1'b1 || pgm_address !== 11'd0 || pgm_data !== 8'd0 || play !== 1'b0 ||
        fill_req !== 1'b0 || src_ready !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_prime we_n=%b addr=%h data=%h play=%b fill=%b rdy=%b unr=%b required 1 000 00 0 0 0 0",
               pgm_we_n, pgm_address, pgm_data, play, fill_req, src_ready, underrun);
    end
    @(posedge clkin); #1;
    src_valid = 1'b0;
    reset_n   = 1'b1;
    @(posedge clkin); #1;
    checks++;
    if (fill_req !== 1'b0 || pgm_we_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_prime_release fill=%b we_n=%b required 0 1", fill_req, pgm_we_n);
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_refill();
    test_backpressure();
    test_underrun();
    test_stop_start();
    test_reset_mid_prime();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
